// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the unified instruction/data memory arbiter.
package mem_arbiter_pkg;

    // Mirrors the global ADDR_SIZE / INSTR_SIZE widths (buses are SIZE+1 wide).
    localparam int unsigned ADDR_SIZE  = 31;
    localparam int unsigned INSTR_SIZE = 31;
    localparam int unsigned ADDR_W     = ADDR_SIZE + 1;
    localparam int unsigned DATA_W     = INSTR_SIZE + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        MA_IDLE   = 2'd0,
        MA_I_BUSY = 2'd1,
        MA_D_BUSY = 2'd2,
        MA_I_DROP = 2'd3
    } ma_state_e;

    // Data has priority unless the instruction port has already waited out
    // its allowance of consecutive data grants.
    function automatic ma_state_e pick_grant(input logic i_req,
                                             input logic d_req,
                                             input logic at_limit);
        ma_state_e g;
        g = MA_IDLE;
        if (d_req && !(i_req && at_limit)) begin
            g = MA_D_BUSY;
        end else if (i_req) begin
            g = MA_I_BUSY;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled as one interface.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // fetch stage
    addr_t i_rd_addr;
    logic  i_rd_enable;
    word_t i_rd_data;
    logic  i_rd_ready;
    // memory stage
    addr_t d_addr;
    word_t d_wdata;
    logic  d_we;
    logic  d_enable;
    word_t d_rdata;
    logic  d_ready;
    // memory model
    addr_t mem_addr;
    word_t mem_wdata;
    logic  mem_we;
    logic  mem_req;
    word_t mem_rdata;
    logic  mem_ack;

    // Arbiter side.
    modport slave (
        input  i_rd_addr, i_rd_enable, d_addr, d_wdata, d_we, d_enable,
               mem_rdata, mem_ack,
        output i_rd_data, i_rd_ready, d_rdata, d_ready,
               mem_addr, mem_wdata, mem_we, mem_req
    );

    // Environment side: both requesters plus the memory model.
    modport master (
        output i_rd_addr, i_rd_enable, d_addr, d_wdata, d_we, d_enable,
               mem_rdata, mem_ack,
        input  i_rd_data, i_rd_ready, d_rdata, d_ready,
               mem_addr, mem_wdata, mem_we, mem_req
    );

endinterface

// File: rtl/mem_arb_fair_cnt.sv
// Saturating count of data grants issued while an instruction request waits.
module mem_arb_fair_cnt #(
    parameter int unsigned FAIR_LIMIT = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(FAIR_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign at_limit = (cnt_q == LIMIT_C);

    // Next count: clear wins, increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_limit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch reads vs. data loads/stores, one
// transaction at a time, data priority with an instruction starvation limit.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned FAIR_LIMIT = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    ma_state_e state_q, state_d;
    ma_state_e gnt;
    addr_t     mem_addr_q, mem_addr_d;
    word_t     mem_wdata_q, mem_wdata_d;
    logic      mem_we_q, mem_we_d;
    logic      mem_req_q, mem_req_d;
    word_t     i_rd_data_q, i_rd_data_d;
    word_t     d_rdata_q, d_rdata_d;
    logic      i_rd_ready_q, i_rd_ready_d;
    logic      d_ready_q, d_ready_d;
    logic      cnt_inc, cnt_clr, at_limit;

    mem_arb_fair_cnt #(
        .FAIR_LIMIT (FAIR_LIMIT),
        .CNT_W      (CNT_W)
    ) u_fair_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .at_limit (at_limit)
    );

    // Arbitration, bus latching and completion handling.
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        mem_req_d    = mem_req_q;
        i_rd_data_d  = i_rd_data_q;
        d_rdata_d    = d_rdata_q;
        i_rd_ready_d = 1'b0;
        d_ready_d    = 1'b0;
        cnt_inc      = 1'b0;
        cnt_clr      = 1'b0;
        gnt          = MA_IDLE;

        case (state_q)
            MA_IDLE: begin
                if (!bus.i_rd_enable) begin
                    cnt_clr = 1'b1;
                end
                gnt = pick_grant(bus.i_rd_enable, bus.d_enable, at_limit);
                case (gnt)
                    MA_D_BUSY: begin
                        state_d     = MA_D_BUSY;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_we_d    = bus.d_we;
                        mem_req_d   = 1'b1;
                        cnt_inc     = bus.i_rd_enable;
                    end
                    MA_I_BUSY: begin
                        state_d    = MA_I_BUSY;
                        mem_addr_d = bus.i_rd_addr;
                        mem_we_d   = 1'b0;
                        mem_req_d  = 1'b1;
                        cnt_clr    = 1'b1;
                    end
                    default: ;
                endcase
            end
            MA_I_BUSY: begin
                // A withdrawal seen together with the ack still discards the data.
                if (bus.mem_ack) begin
                    state_d   = MA_IDLE;
                    mem_req_d = 1'b0;
                    if (bus.i_rd_enable) begin
                        i_rd_ready_d = 1'b1;
                        i_rd_data_d  = bus.mem_rdata;
                    end
                end else if (!bus.i_rd_enable) begin
                    state_d = MA_I_DROP;
                end
            end
            MA_I_DROP: begin
                if (bus.mem_ack) begin
                    state_d   = MA_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            MA_D_BUSY: begin
                if (bus.mem_ack) begin
                    state_d   = MA_IDLE;
                    mem_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: state_d = MA_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= MA_IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            i_rd_data_q  <= '0;
            d_rdata_q    <= '0;
            i_rd_ready_q <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_req_q    <= mem_req_d;
            i_rd_data_q  <= i_rd_data_d;
            d_rdata_q    <= d_rdata_d;
            i_rd_ready_q <= i_rd_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

`ifdef SIMULATE
    // Flag a data requester that withdraws mid-transaction; completion still proceeds.
    always_ff @(posedge clk) begin
        if (!reset && state_q == MA_D_BUSY && !bus.d_enable) begin
            $display("mem_arbiter: warning: d_enable dropped during data transaction at %0t", $time);
        end
    end
`endif

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.i_rd_data  = i_rd_data_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.i_rd_ready = i_rd_ready_q;
    assign bus.d_ready    = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned FAIR_LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .FAIR_LIMIT (FAIR_LIMIT),
        .CNT_W      (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] memm [logic [31:0]];
    logic [31:0] refm [logic [31:0]];

    bit          auto_mem;
    int          ack_delay;
    int          wait_cnt;
    int          req_hi, i_rdy, d_rdy, bus_bad;
    logic [31:0] i_rdy_data, d_rdy_data;
    logic [31:0] glog [$];
    logic        prev_req;

    // random-phase model state
    int          pend;        // 0 none, 1 instruction read, 2 data transaction
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    int          d_run;       // data grants in a row while the fetch port waits
    logic [31:0] exp_idata, exp_ddata;
    logic        exp_irdy, exp_drdy;
    logic        ie, de, ack;
    bit          mid_seen;
    logic [9:0]  order;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return memm.exists(a) ? memm[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : dflt(a);
    endfunction

    function automatic logic [31:0] raddr();
        return 32'h1000 + ($urandom_range(0, 7) << 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_acc();
        req_hi = 0; i_rdy = 0; d_rdy = 0; bus_bad = 0;
        glog.delete();
    endtask

    // One clock: sample just after the edge, then let the memory model respond.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.mem_req === 1'b1) req_hi++;
        if (bus.i_rd_ready === 1'b1) begin i_rdy++; i_rdy_data = bus.i_rd_data; end
        if (bus.d_ready === 1'b1) begin d_rdy++; d_rdy_data = bus.d_rdata; end
        if (bus.mem_req === 1'b1 && prev_req !== 1'b1) glog.push_back(bus.mem_addr);
        prev_req = bus.mem_req;
        if (auto_mem) begin
            bus.mem_ack = 1'b0;
            if (bus.mem_req === 1'b1 && !reset) begin
                if (wait_cnt >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    wait_cnt = 0;
                    if (bus.mem_we === 1'b1) memm[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem_rd(bus.mem_addr);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    endtask

    task automatic run_txn(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit we, input int dly);
        bit done;
        done = 1'b0;
        clear_acc();
        ack_delay = dly;
        if (is_d) begin
            bus.d_addr = addr; bus.d_wdata = wdata; bus.d_we = we; bus.d_enable = 1'b1;
        end else begin
            bus.i_rd_addr = addr; bus.i_rd_enable = 1'b1;
        end
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (bus.mem_req === 1'b1 &&
                (bus.mem_addr !== addr || bus.mem_we !== we || (we && bus.mem_wdata !== wdata)))
                bus_bad++;
            if (i_rdy + d_rdy != 0) begin
                done = 1'b1;
                bus.i_rd_enable = 1'b0;
                bus.d_enable = 1'b0;
            end
        end
        bus.i_rd_enable = 1'b0;
        bus.d_enable = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_mem_req"},    32'(bus.mem_req), 0);
        check({pfx, "_mem_addr"},   bus.mem_addr, 0);
        check({pfx, "_mem_wdata"},  bus.mem_wdata, 0);
        check({pfx, "_mem_we"},     32'(bus.mem_we), 0);
        check({pfx, "_i_rd_ready"}, 32'(bus.i_rd_ready), 0);
        check({pfx, "_d_ready"},    32'(bus.d_ready), 0);
        check({pfx, "_i_rd_data"},  bus.i_rd_data, 0);
        check({pfx, "_d_rdata"},    bus.d_rdata, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; auto_mem = 1'b1; ack_delay = 0; wait_cnt = 0; prev_req = 1'b0;
        bus.i_rd_addr = '0; bus.i_rd_enable = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_we = 1'b0; bus.d_enable = 1'b0;
        bus.mem_rdata = '0; bus.mem_ack = 1'b0;
        memm[32'h10] = 32'hDEADBEEF;
        memm[32'h44] = 32'hCAFEF00D;
        memm[32'h20] = 32'h20202020;
        memm[32'h80] = 32'h80808080;

        // reset state
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // single instruction read, ack delay 2
        run_txn(1'b0, 32'h10, 32'h0, 1'b0, 2);
        check("ird_req_cycles", req_hi, 3);
        check("ird_ready_pulses", i_rdy, 1);
        check("ird_no_dready", d_rdy, 0);
        check("ird_bus_we0", bus_bad, 0);
        check("ird_data", i_rdy_data, 32'hDEADBEEF);
        tick();
        check("ird_ready_low", 32'(bus.i_rd_ready), 0);
        check("ird_data_hold", bus.i_rd_data, 32'hDEADBEEF);

        // load then store, store must leave d_rdata alone
        run_txn(1'b1, 32'h44, 32'h0, 1'b0, 1);
        check("load_req_cycles", req_hi, 2);
        check("load_ready", d_rdy, 1);
        check("load_data", d_rdy_data, 32'hCAFEF00D);
        run_txn(1'b1, 32'h40, 32'h12345678, 1'b1, 0);
        check("store_req_cycles", req_hi, 1);
        check("store_ready", d_rdy, 1);
        check("store_no_iready", i_rdy, 0);
        check("store_bus", bus_bad, 0);
        tick();
        check("store_rdata_kept", bus.d_rdata, 32'hCAFEF00D);
        check("store_mem", mem_rd(32'h40), 32'h12345678);
        check("store_ready_low", 32'(bus.d_ready), 0);

        // both ports continuously requesting
        clear_acc();
        ack_delay = 1;
        bus.i_rd_addr = 32'h100; bus.d_addr = 32'h200; bus.d_we = 1'b0;
        bus.i_rd_enable = 1'b1; bus.d_enable = 1'b1;
        for (int k = 0; k < 300 && (i_rdy + d_rdy) < 10; k++) tick();
        bus.i_rd_enable = 1'b0; bus.d_enable = 1'b0;
        tick(); tick();
        check("fair_grants", glog.size(), 10);
        order = '0;
        for (int k = 0; k < 10 && k < glog.size(); k++) order[k] = (glog[k] == 32'h100);
        check("fair_order", 32'(order), 32'h210);
        check("fair_i_ready", i_rdy, 2);

        // flush abort of a fetch, new fetch raised while the old read drains
        clear_acc();
        mid_seen = 1'b0;
        ack_delay = 3;
        bus.i_rd_addr = 32'h20; bus.i_rd_enable = 1'b1;
        tick();
        check("flush_gnt_req", 32'(bus.mem_req), 1);
        check("flush_gnt_addr", bus.mem_addr, 32'h20);
        tick();
        bus.i_rd_enable = 1'b0;
        tick();
        bus.i_rd_addr = 32'h80; bus.i_rd_enable = 1'b1;
        for (int k = 0; k < 40 && i_rdy == 0; k++) begin
            tick();
            if (glog.size() == 2 && !mid_seen) begin
                mid_seen = 1'b1;
                check("flush_no_stale_ready", i_rdy, 0);
                check("flush_data_held", bus.i_rd_data, dflt(32'h100));
            end
        end
        bus.i_rd_enable = 1'b0;
        tick();
        check("flush_regrant_seen", 32'(mid_seen), 1);
        check("flush_grants", glog.size(), 2);
        if (glog.size() == 2) begin
            check("flush_first_addr", glog[0], 32'h20);
            check("flush_second_addr", glog[1], 32'h80);
        end
        check("flush_ready_pulses", i_rdy, 1);
        check("flush_data", i_rdy_data, 32'h80808080);

        // reset while a data transaction is in flight
        auto_mem = 1'b0;
        bus.mem_ack = 1'b0;
        bus.d_addr = 32'h60; bus.d_we = 1'b0; bus.d_enable = 1'b1;
        tick();
        check("rst_gnt_req", 32'(bus.mem_req), 1);
        tick();
        reset = 1'b1; bus.d_enable = 1'b0;
        tick();
        check_all_zero("rst_mid");
        reset = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h66666666;
        tick();
        bus.mem_ack = 1'b0;
        check("rst_late_ack_dready", 32'(bus.d_ready), 0);
        check("rst_late_ack_req", 32'(bus.mem_req), 0);
        check("rst_late_ack_rdata", bus.d_rdata, 0);
        auto_mem = 1'b1;
        run_txn(1'b1, 32'h44, 32'h0, 1'b0, 2);
        check("rst_fresh_req_cycles", req_hi, 3);
        check("rst_fresh_ready", d_rdy, 1);
        check("rst_fresh_data", d_rdy_data, 32'hCAFEF00D);

        // ack in the same cycle the fetch request falls
        clear_acc();
        ack_delay = 2;
        bus.i_rd_addr = 32'h30; bus.i_rd_enable = 1'b1;
        tick(); tick(); tick();
        bus.i_rd_enable = 1'b0;
        tick();
        check("drop_ack_no_ready", 32'(bus.i_rd_ready), 0);
        check("drop_ack_req_low", 32'(bus.mem_req), 0);
        check("drop_ack_data_kept", bus.i_rd_data, 0);
        tick();
        check("drop_ack_still_no_ready", i_rdy, 0);
        run_txn(1'b0, 32'h34, 32'h0, 1'b0, 0);
        check("drop_next_req_cycles", req_hi, 1);
        check("drop_next_ready", i_rdy, 1);
        check("drop_next_data", i_rdy_data, dflt(32'h34));

        // randomized traffic against a transaction-level model
        reset = 1'b1;
        bus.i_rd_enable = 1'b0; bus.d_enable = 1'b0;
        tick(); tick();
        reset = 1'b0;
        pend = 0; d_run = 0; exp_idata = '0; exp_ddata = '0;
        p_addr = '0; p_wdata = '0; p_we = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            ie = bus.i_rd_enable; de = bus.d_enable; ack = bus.mem_ack;
            exp_irdy = 1'b0; exp_drdy = 1'b0;
            if (pend == 0) begin
                if (de && ie && d_run < FAIR_LIMIT) begin pend = 2; d_run++; end
                else if (ie) begin pend = 1; d_run = 0; end
                else if (de) begin pend = 2; d_run = 0; end
                else d_run = 0;
                if (pend == 1) begin p_addr = bus.i_rd_addr; p_we = 1'b0; end
                else if (pend == 2) begin p_addr = bus.d_addr; p_we = bus.d_we; p_wdata = bus.d_wdata; end
            end else if (ack) begin
                if (pend == 1) begin
                    exp_irdy = 1'b1; exp_idata = ref_rd(p_addr);
                end else begin
                    exp_drdy = 1'b1;
                    if (p_we) refm[p_addr] = p_wdata;
                    else exp_ddata = ref_rd(p_addr);
                end
                pend = 0;
            end
            tick();
            check("rnd_mem_req", 32'(bus.mem_req), 32'(pend != 0));
            check("rnd_i_ready", 32'(bus.i_rd_ready), 32'(exp_irdy));
            check("rnd_d_ready", 32'(bus.d_ready), 32'(exp_drdy));
            check("rnd_i_data", bus.i_rd_data, exp_idata);
            check("rnd_d_data", bus.d_rdata, exp_ddata);
            if (pend != 0) begin
                check("rnd_mem_addr", bus.mem_addr, p_addr);
                check("rnd_mem_we", 32'(bus.mem_we), 32'(p_we));
                if (p_we) check("rnd_mem_wdata", bus.mem_wdata, p_wdata);
            end
            if (bus.i_rd_ready === 1'b1) begin
                if ($urandom_range(0, 1) == 1) bus.i_rd_addr = raddr();
                else bus.i_rd_enable = 1'b0;
            end else if (!bus.i_rd_enable && $urandom_range(0, 2) == 0) begin
                bus.i_rd_enable = 1'b1; bus.i_rd_addr = raddr();
            end
            if (bus.d_ready === 1'b1) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.d_addr = raddr(); bus.d_we = 1'($urandom_range(0, 1)); bus.d_wdata = $urandom;
                end else begin
                    bus.d_enable = 1'b0;
                end
            end else if (!bus.d_enable && $urandom_range(0, 2) == 0) begin
                bus.d_enable = 1'b1; bus.d_addr = raddr();
                bus.d_we = 1'($urandom_range(0, 1)); bus.d_wdata = $urandom;
            end
            if (bus.mem_req !== 1'b1) ack_delay = $urandom_range(0, 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sits between both pipeline stages and the memory model.
- Sequences one memory transaction at a time.
- Arbitrates with data-priority plus a starvation limit.
- Cleanly discards an instruction response whose request was withdrawn by a fetch flush.

Parameters:
- FAIR_LIMIT, 4: max consecutive data grants while an instruction request waits; the next grant then goes to the instruction port.
- CNT_W, 3: width of the fairness counter; must satisfy 2^CNT_W > FAIR_LIMIT.

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  reset, synchronous, active-high
- i_rd_addr  in  `ADDR_SIZE+1  instruction read address
- i_rd_enable  in  1  instruction request; level, held until i_rd_ready; may drop early on flush
- i_rd_data  out  `INSTR_SIZE+1  instruction read data
- i_rd_ready  out  1  one-cycle pulse, i_rd_data valid
- d_addr  in  `ADDR_SIZE+1  data address
- d_wdata  in  `INSTR_SIZE+1  store data
- d_we  in  1  1=store, 0=load
- d_enable  in  1  data request; level, held until d_ready
- d_rdata  out  `INSTR_SIZE+1  load data
- d_ready  out  1  one-cycle pulse, transaction complete
- mem_addr  out  `ADDR_SIZE+1  memory address
- mem_wdata  out  `INSTR_SIZE+1  memory write data
- mem_we  out  1  memory write enable
- mem_req  out  1  memory request, held until mem_ack
- mem_rdata  in  `INSTR_SIZE+1  memory read data
- mem_ack  in  1  memory completion, single cycle, any latency >=0 after mem_req

Behaviour:
- Reset values: all outputs 0 (including data buses); state IDLE; fairness counter 0.
- Reset mid-transaction:
  - mem_req drops on the next edge and the pending response is lost.
  - The memory model must tolerate an abandoned request.
- States:
  - IDLE: no transaction.
  - I_BUSY: instruction read in flight.
  - D_BUSY: data transaction in flight.
  - I_DROP: instruction read in flight, requester withdrew.
- IDLE arbitration, evaluated each posedge, registered:
  - Only d_enable: go to D_BUSY.
  - Only i_rd_enable: go to I_BUSY.
  - Both asserted and counter < FAIR_LIMIT: D_BUSY, counter +1.
  - Both asserted and counter == FAIR_LIMIT: I_BUSY.
  - Counter clears on any instruction grant, and whenever i_rd_enable is low in IDLE.
  - Neither asserted: stay in IDLE.
- On grant: mem_addr, mem_wdata and mem_we are latched from the granted port; mem_req=1 on the same edge.
  - mem_we is always 0 for instruction grants.
  - Bus values are held stable until mem_ack.
- BUSY states, on the posedge where mem_ack=1:
  - mem_req goes to 0; state returns to IDLE.
  - The matching ready pulses high for exactly that following cycle.
  - Read data is captured from mem_rdata into i_rd_data or d_rdata.
  - d_rdata is unchanged on stores.
  - Captured data holds until the next completion on the same port.
- Latency:
  - Request seen at edge N: mem_req high from N.
  - mem_ack at edge N+k: ready high during cycle N+k.
  - The arbiter returns to IDLE at N+k and may grant again at N+k+1, so back-to-back transactions need at least one IDLE cycle.
- Flush abort:
  - In I_BUSY, i_rd_enable sampled low before mem_ack moves the state to I_DROP.
  - mem_req stays high until mem_ack.
  - On ack: i_rd_ready stays 0, i_rd_data is unchanged, state goes to IDLE.
  - A new instruction request raised while in I_DROP is not served until IDLE, so the stale data is never returned.
- Simultaneous events:
  - mem_ack in the same cycle as i_rd_enable falling: treated as a drop, no ready.
  - d_enable dropping during D_BUSY is a protocol error. Completion proceeds, d_ready still pulses, and a SIMULATE $display warning is printed.
- Requester-side contract: ready is a pulse, not a level. A requester deasserts enable on the edge after ready or issues its next address.

Decomposition:
- Shared params file (existing global include):
  - State encodings MA_IDLE=2'd0, MA_I_BUSY=2'd1, MA_D_BUSY=2'd2, MA_I_DROP=2'd3.
  - Existing `ADDR_SIZE and `INSTR_SIZE.
- One sub-module is natural: mem_arb_fair_cnt, the saturating fairness counter with increment, clear, and at_limit output.
- The FSM and datapath latches stay in mem_arbiter.

Test Plan:
- Single instruction read, addr 0x10, memory ack delay 2: mem_req high 3 cycles, i_rd_ready pulses once with mem_rdata 0xDEADBEEF, mem_we stays 0.
- Store addr 0x40, wdata 0x12345678, ack delay 0: mem_we=1 and mem_wdata correct while mem_req high, d_ready pulses 1 cycle, d_rdata unchanged.
- Both ports request continuously, FAIR_LIMIT=4: grant order D,D,D,D,I,D,D,D,D,I; no instruction wait exceeds 4 data transactions.
- Flush abort: instruction grant at 0x20, i_rd_enable drops 1 cycle later, then rises at 0x80 before ack, ack delay 3: no ready for 0x20; 0x80 granted after IDLE; i_rd_ready returns 0x80 data only.
- Reset asserted during D_BUSY before ack: next cycle all outputs 0, state IDLE; a later ack while reset is low is ignored; a fresh request completes normally.
- Ack in the same cycle as i_rd_enable falling: no i_rd_ready, state IDLE the next cycle.
